// File: rtl/divide_controller.sv
// Multi-cycle restoring divider controller for the EX stage.
// Accepts one DIV/DIVU request at a time, iterates one quotient bit per
// cycle MSB first, and holds the sign-corrected result until consumed.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// WAITING_STATE | idle, divide_ready high, request accepted on valid & !flush
// LOAD_STATE    | form operand magnitudes, record result signs, clear counter
// DIVIDE_STATE  | one shift-subtract iteration per cycle, DATA_WIDTH cycles
// RETURN_STATE  | result valid and stable until result_ready
module divide_controller #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  divide_valid,
    input  logic                  divide_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  divide_ready,
    input  logic                  flush,
    input  logic                  result_ready,
    output logic                  divide_result_valid,
    output logic [DATA_WIDTH-1:0] divide_result,
    output logic [DATA_WIDTH-1:0] divide_remain,
    output logic                  busy
);

    typedef enum logic [1:0] {
        WAITING_STATE = 2'b00,
        LOAD_STATE    = 2'b01,
        DIVIDE_STATE  = 2'b10,
        RETURN_STATE  = 2'b11
    } state_t;

    localparam logic [5:0] LAST_COUNT = 6'(DATA_WIDTH - 1);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   dividend_q;
    logic [DATA_WIDTH-1:0]   divisor_q;
    logic                    signed_q;
    logic [DATA_WIDTH-1:0]   divisor_abs;
    logic [DATA_WIDTH-1:0]   quot_q;
    logic [DATA_WIDTH-1:0]   rem_q;
    logic                    quot_neg;
    logic                    rem_neg;
    logic                    div_zero;
    logic [5:0]              count;

    logic [DATA_WIDTH:0]     shifted;
    logic [DATA_WIDTH:0]     diff;
    logic [DATA_WIDTH-1:0]   quot_next;
    logic [DATA_WIDTH-1:0]   rem_next;
    logic [DATA_WIDTH-1:0]   quot_final;
    logic [DATA_WIDTH-1:0]   rem_final;

    function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] value);
        return ~value + 1'b1;
    endfunction

    assign divide_ready = (state == WAITING_STATE);
    assign busy         = (state != WAITING_STATE);

    // One restoring iteration; the borrow bit of the W+1 bit difference
    // tells whether the shifted partial remainder reached the divisor.
    always_comb begin
        shifted = {rem_q, quot_q[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, divisor_abs};
        if (!diff[DATA_WIDTH]) begin
            rem_next  = diff[DATA_WIDTH-1:0];
            quot_next = {quot_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = shifted[DATA_WIDTH-1:0];
            quot_next = {quot_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction of the last iteration's output. A zero divisor is
    // forced to all-ones / original dividend regardless of mode.
    always_comb begin
        quot_final = quot_neg ? negate(quot_next) : quot_next;
        rem_final  = rem_neg  ? negate(rem_next)  : rem_next;
        if (div_zero) begin
            quot_final = '1;
            rem_final  = dividend_q;
        end
    end

    // Controller FSM with registered result outputs; flush overrides everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= WAITING_STATE;
            dividend_q          <= '0;
            divisor_q           <= '0;
            signed_q            <= 1'b0;
            divisor_abs         <= '0;
            quot_q              <= '0;
            rem_q               <= '0;
            quot_neg            <= 1'b0;
            rem_neg             <= 1'b0;
            div_zero            <= 1'b0;
            count               <= '0;
            divide_result_valid <= 1'b0;
            divide_result       <= '0;
            divide_remain       <= '0;
        end else if (flush) begin
            state               <= WAITING_STATE;
            divide_result_valid <= 1'b0;
        end else begin
            case (state)
                WAITING_STATE: begin
                    if (divide_valid) begin
                        dividend_q <= dividend;
                        divisor_q  <= divisor;
                        signed_q   <= divide_signed;
                        state      <= LOAD_STATE;
                    end
                end
                LOAD_STATE: begin
                    quot_q      <= (signed_q && dividend_q[DATA_WIDTH-1]) ? negate(dividend_q) : dividend_q;
                    divisor_abs <= (signed_q && divisor_q[DATA_WIDTH-1])  ? negate(divisor_q)  : divisor_q;
                    quot_neg    <= signed_q & (dividend_q[DATA_WIDTH-1] ^ divisor_q[DATA_WIDTH-1]);
                    rem_neg     <= signed_q & dividend_q[DATA_WIDTH-1];
                    div_zero    <= (divisor_q == '0);
                    rem_q       <= '0;
                    count       <= '0;
                    state       <= DIVIDE_STATE;
                end
                DIVIDE_STATE: begin
                    quot_q <= quot_next;
                    rem_q  <= rem_next;
                    count  <= count + 6'd1;
                    if (count == LAST_COUNT) begin
                        divide_result       <= quot_final;
                        divide_remain       <= rem_final;
                        divide_result_valid <= 1'b1;
                        state               <= RETURN_STATE;
                    end
                end
                RETURN_STATE: begin
                    if (result_ready) begin
                        divide_result_valid <= 1'b0;
                        state               <= WAITING_STATE;
                    end
                end
                default: begin
                    divide_result_valid <= 1'b0;
                    state               <= WAITING_STATE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divide_controller.sv
// Directed bench for divide_controller: scoreboard of expected quotient /
// remainder pairs, checked with immediate assertions as results appear.
module tb_divide_controller;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         divide_valid = 1'b0;
    logic         divide_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         flush = 1'b0;
    logic         result_ready = 1'b0;
    logic         divide_ready;
    logic         divide_result_valid;
    logic [W-1:0] divide_result;
    logic [W-1:0] divide_remain;
    logic         busy;

    int tests = 0;
    int failed = 0;
    logic [2*W-1:0] sb_q[$];

    divide_controller #(.DATA_WIDTH(W)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .divide_valid        (divide_valid),
        .divide_signed       (divide_signed),
        .dividend            (dividend),
        .divisor             (divisor),
        .divide_ready        (divide_ready),
        .flush               (flush),
        .result_ready        (result_ready),
        .divide_result_valid (divide_result_valid),
        .divide_result       (divide_result),
        .divide_remain       (divide_remain),
        .busy                (busy)
    );

    always #5 clock = ~clock;

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: native SV division plus the two architecturally defined corner cases.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
            return {32'(sa / sb), 32'(sa % sb)};
        end
        return {a / b, a % b};
    endfunction

    // Called at a negedge in WAITING; the caller has pushed the expected pair.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int hold);
        logic [63:0] exp;
        int cyc;
        divide_valid  = 1'b1;
        dividend      = a;
        divisor       = b;
        divide_signed = sgn;
        check1("ready_idle", divide_ready, 1'b1);
        @(posedge clock);
        @(negedge clock);
        divide_valid  = 1'b0;
        dividend      = $urandom;
        divisor       = $urandom;
        divide_signed = ~sgn;
        cyc = 1;
        while (!divide_result_valid && cyc < 100) begin
            check1("busy_in_op", busy, 1'b1);
            @(negedge clock);
            cyc++;
        end
        check32("latency", cyc, 32'd34);
        if (!divide_result_valid) begin
            void'(sb_q.pop_front());
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check1("valid_hold", divide_result_valid, 1'b1);
            check1("ready_low_return", divide_ready, 1'b0);
            check32("quot_hold", divide_result, sb_q[0][63:32]);
            check32("rem_hold", divide_remain, sb_q[0][31:0]);
            @(negedge clock);
        end
        result_ready = 1'b1;
        exp = sb_q.pop_front();
        check1("valid", divide_result_valid, 1'b1);
        check32("quotient", divide_result, exp[63:32]);
        check32("remainder", divide_remain, exp[31:0]);
        @(negedge clock);
        result_ready = 1'b0;
        check1("valid_cleared", divide_result_valid, 1'b0);
        check1("busy_after", busy, 1'b0);
        check1("ready_after", divide_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          cyc;

        repeat (2) @(negedge clock);
        check1("rst_ready", divide_ready, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check1("rst_valid", divide_result_valid, 1'b0);
        check32("rst_quot", divide_result, 32'h0);
        check32("rst_rem", divide_remain, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        sb_q.push_back({32'd14, 32'd2});
        run_div(32'd100, 32'd7, 1'b0, 0);
        sb_q.push_back({32'hFFFF_FFFD, 32'hFFFF_FFFF});
        run_div(32'hFFFF_FFF9, 32'h2, 1'b1, 0);
        sb_q.push_back({32'hFFFF_FFFD, 32'h1});
        run_div(32'h7, 32'hFFFF_FFFE, 1'b1, 0);
        sb_q.push_back({32'h8000_0000, 32'h0});
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        sb_q.push_back({32'hFFFF_FFFF, 32'h1234_5678});
        run_div(32'h1234_5678, 32'h0, 1'b0, 0);
        sb_q.push_back({32'hFFFF_FFFF, 32'h8000_0005});
        run_div(32'h8000_0005, 32'h0, 1'b1, 1);
        sb_q.push_back({32'd30, 32'd10});
        run_div(32'd1000, 32'd33, 1'b0, 3);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            rs = i[0];
            sb_q.push_back(model(ra, rb, rs));
            run_div(ra, rb, rs, i % 3);
        end

        // Flush in DIVIDE cycle 10, then a fresh request in the next cycle.
        divide_valid  = 1'b1;
        dividend      = 32'd100;
        divisor       = 32'd7;
        divide_signed = 1'b0;
        @(posedge clock);
        @(negedge clock);
        divide_valid = 1'b0;
        repeat (9) @(negedge clock);
        check1("busy_before_flush", busy, 1'b1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check1("flush_valid", divide_result_valid, 1'b0);
        check1("flush_busy", busy, 1'b0);
        check1("flush_ready", divide_ready, 1'b1);
        sb_q.push_back({32'd3, 32'd0});
        run_div(32'd9, 32'd3, 1'b0, 0);

        // Flush wins over result_ready in RETURN: result discarded.
        divide_valid = 1'b1;
        dividend     = 32'd50;
        divisor      = 32'd7;
        @(posedge clock);
        @(negedge clock);
        divide_valid = 1'b0;
        cyc = 1;
        while (!divide_result_valid && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        check1("ret_reached", divide_result_valid, 1'b1);
        flush        = 1'b1;
        result_ready = 1'b1;
        @(negedge clock);
        flush        = 1'b0;
        result_ready = 1'b0;
        check1("ret_flush_valid", divide_result_valid, 1'b0);
        check1("ret_flush_busy", busy, 1'b0);

        // Flush concurrent with a request in WAITING is not accepted.
        divide_valid = 1'b1;
        flush        = 1'b1;
        dividend     = 32'd77;
        divisor      = 32'd5;
        @(negedge clock);
        divide_valid = 1'b0;
        flush        = 1'b0;
        check1("flush_req_busy", busy, 1'b0);
        check1("flush_req_ready", divide_ready, 1'b1);
        @(negedge clock);
        check1("flush_req_valid", divide_result_valid, 1'b0);

        // Asynchronous reset mid-DIVIDE; held result registers hold 7 / 1 beforehand.
        divide_valid = 1'b1;
        dividend     = 32'd100;
        divisor      = 32'd7;
        @(posedge clock);
        @(negedge clock);
        divide_valid = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check1("arst_valid", divide_result_valid, 1'b0);
        check32("arst_quot", divide_result, 32'h0);
        check32("arst_rem", divide_remain, 32'h0);
        check1("arst_busy", busy, 1'b0);
        check1("arst_ready", divide_ready, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        sb_q.push_back({32'd15, 32'd2});
        run_div(32'd77, 32'd5, 1'b0, 0);

        check32("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
